// File: rtl/rv_pkg.sv
// Shared RV32I core constants: data width, register count, register address width
// and the architectural zero register index.
package rv_pkg;
   localparam int XLEN = 32;
   localparam int NREG = 32;
   localparam int AW   = $clog2(NREG);
   localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/regfile_sb_bits.sv
// Pending-write bit vector for the register scoreboard: flush beats set, set beats clear.
module regfile_sb_bits #(
   parameter int NREG     = rv_pkg::NREG,
   parameter int AW       = rv_pkg::AW,
   parameter int ZERO_REG = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush_i,
   input  logic            set_valid_i,
   input  logic [AW-1:0]   set_addr_i,
   input  logic            clr_valid_i,
   input  logic [AW-1:0]   clr_addr_i,
   output logic [NREG-1:0] pend_o
);
   // Register 0 can never become pending when it is hardwired to zero.
   localparam logic [NREG-1:0] ONE_HOT0 = {{(NREG-1){1'b0}}, 1'b1};
   localparam logic [NREG-1:0] KEEP     = (ZERO_REG != 0) ? ~ONE_HOT0 : {NREG{1'b1}};

   logic [NREG-1:0] pend_q, pend_d;
   logic [NREG-1:0] set_mask_s, clr_mask_s;

   assign set_mask_s = set_valid_i ? ((ONE_HOT0 << set_addr_i) & KEEP) : {NREG{1'b0}};
   assign clr_mask_s = clr_valid_i ? (ONE_HOT0 << clr_addr_i) : {NREG{1'b0}};

   // Next pending state: a same-cycle set on the cleared register keeps it pending.
   always_comb begin
      pend_d = pend_q;
      if (flush_i) begin
         pend_d = {NREG{1'b0}};
      end else begin
         pend_d = (pend_q & ~clr_mask_s) | set_mask_s;
      end
   end

   // Pending flops with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pend_q <= {NREG{1'b0}};
      end else begin
         pend_q <= pend_d;
      end
   end

   assign pend_o = pend_q;
endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-read-port integer register file with write-back bypass and a pending-write
// scoreboard producing per-port RAW busy flags and a WAW issue_ready flag.
module regfile_scoreboard #(
   parameter int XLEN     = rv_pkg::XLEN,
   parameter int NREG     = rv_pkg::NREG,
   parameter int NRD      = 2,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 1,
   parameter int AW       = $clog2(NREG)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NRD*AW-1:0]   rd_addr,
   output logic [NRD*XLEN-1:0] rd_data,
   output logic [NRD-1:0]      rd_busy,
   input  logic                issue_valid,
   input  logic [AW-1:0]       issue_rd,
   output logic                issue_ready,
   input  logic                wb_valid,
   input  logic [AW-1:0]       wb_addr,
   input  logic [XLEN-1:0]     wb_data,
   input  logic                flush
);
   import rv_pkg::*;

   localparam logic [AW-1:0] ZADDR = AW'(REG_ZERO);

   logic [XLEN-1:0] regs_q [NREG];
   logic [NREG-1:0] pend_s;
   logic            wb_zero_s;
   logic            issue_zero_s;
   logic            issue_go_s;

   assign wb_zero_s    = (ZERO_REG != 0) && (wb_addr == ZADDR);
   assign issue_zero_s = (ZERO_REG != 0) && (issue_rd == ZADDR);

   // A write-back landing this cycle frees its register for a new issue.
   assign issue_ready = rst_n && (!pend_s[issue_rd] || (wb_valid && (wb_addr == issue_rd)) || issue_zero_s);
   assign issue_go_s  = issue_valid && issue_ready;

   // Architectural storage; reset wins over a same-cycle write-back.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= {XLEN{1'b0}};
         end
      end else if (wb_valid && !wb_zero_s) begin
         regs_q[wb_addr] <= wb_data;
      end else begin
         regs_q[wb_addr] <= regs_q[wb_addr];
      end
   end

   regfile_sb_bits #(
      .NREG     (NREG),
      .AW       (AW),
      .ZERO_REG (ZERO_REG)
   ) u_sb_bits (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush_i     (flush),
      .set_valid_i (issue_go_s),
      .set_addr_i  (issue_rd),
      .clr_valid_i (wb_valid),
      .clr_addr_i  (wb_addr),
      .pend_o      (pend_s)
   );

   for (genvar k = 0; k < NRD; k++) begin : g_rd
      logic [AW-1:0] a_s;
      logic          zero_s;
      logic          hit_s;

      assign a_s    = rd_addr[k*AW +: AW];
      assign zero_s = (ZERO_REG != 0) && (a_s == ZADDR);
      assign hit_s  = (BYPASS != 0) && wb_valid && (wb_addr == a_s);

      assign rd_data[k*XLEN +: XLEN] = (!rst_n || zero_s) ? {XLEN{1'b0}} :
                                       hit_s              ? wb_data      :
                                                            regs_q[a_s];
      assign rd_busy[k] = rst_n && pend_s[a_s] && !hit_s && !zero_s;
   end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: a bypassing instance and a non-bypassing
// instance share all inputs; each scenario task checks its own outputs.
module tb_regfile_scoreboard;
   logic        clk;
   logic        rst_n;
   logic [9:0]  rd_addr;
   logic [63:0] rd_data, rd_data_nb;
   logic [1:0]  rd_busy, rd_busy_nb;
   logic        issue_valid;
   logic [4:0]  issue_rd;
   logic        issue_ready, issue_ready_nb;
   logic        wb_valid;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        flush;

   int n_checks;
   int n_fail;

   regfile_scoreboard #(.BYPASS(1)) dut (
      .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
      .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
      .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush)
   );

   regfile_scoreboard #(.BYPASS(0)) dut_nb (
      .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
      .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready_nb),
      .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic idle();
      issue_valid = 1'b0;
      issue_rd    = 5'd0;
      wb_valid    = 1'b0;
      wb_addr     = 5'd0;
      wb_data     = 32'd0;
      flush       = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle();
      rd_addr  = {5'd2, 5'd1};
      issue_rd = 5'd1;
      #1;
      n_checks++; if (rd_data !== 64'd0) begin n_fail++; $display("FAIL reset_gate_data got %h exp %h", rd_data, 64'd0); end
      n_checks++; if (rd_busy !== 2'b00) begin n_fail++; $display("FAIL reset_gate_busy got %b exp %b", rd_busy, 2'b00); end
      n_checks++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL reset_gate_ready got %b exp %b", issue_ready, 1'b0); end
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int a = 0; a < 32; a++) begin
         rd_addr = {5'(a), 5'(31 - a)};
         #1;
         n_checks++; if (rd_data !== 64'd0) begin n_fail++; $display("FAIL reset_read_data a=%0d got %h exp %h", a, rd_data, 64'd0); end
         n_checks++; if (rd_busy !== 2'b00) begin n_fail++; $display("FAIL reset_read_busy a=%0d got %b exp %b", a, rd_busy, 2'b00); end
      end
      issue_rd = 5'd12;
      #1;
      n_checks++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp %b", issue_ready, 1'b1); end
   endtask

   task automatic test_write_bypass();
      @(negedge clk);
      idle();
      rd_addr  = {5'd0, 5'd5};
      wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF;
      #1;
      n_checks++; if (rd_data[31:0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL bypass_same_cycle got %h exp %h", rd_data[31:0], 32'hDEADBEEF); end
      n_checks++; if (rd_data_nb[31:0] !== 32'h0) begin n_fail++; $display("FAIL nobypass_old got %h exp %h", rd_data_nb[31:0], 32'h0); end
      @(negedge clk);
      idle();
      #1;
      n_checks++; if (rd_data[31:0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL stored_x5 got %h exp %h", rd_data[31:0], 32'hDEADBEEF); end
      n_checks++; if (rd_data_nb[31:0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL stored_x5_nb got %h exp %h", rd_data_nb[31:0], 32'hDEADBEEF); end
   endtask

   task automatic test_x0();
      @(negedge clk);
      idle();
      rd_addr     = {5'd0, 5'd0};
      wb_valid    = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFFFFFF;
      issue_valid = 1'b1; issue_rd = 5'd0;
      #1;
      n_checks++; if (rd_data !== 64'd0) begin n_fail++; $display("FAIL x0_bypass got %h exp %h", rd_data, 64'd0); end
      n_checks++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL x0_ready got %b exp %b", issue_ready, 1'b1); end
      @(negedge clk);
      idle();
      rd_addr = {5'd0, 5'd0};
      #1;
      n_checks++; if (rd_data !== 64'd0) begin n_fail++; $display("FAIL x0_stored got %h exp %h", rd_data, 64'd0); end
      n_checks++; if (rd_data_nb !== 64'd0) begin n_fail++; $display("FAIL x0_stored_nb got %h exp %h", rd_data_nb, 64'd0); end
      n_checks++; if (rd_busy !== 2'b00) begin n_fail++; $display("FAIL x0_busy got %b exp %b", rd_busy, 2'b00); end
      n_checks++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL x0_ready_after got %b exp %b", issue_ready, 1'b1); end
   endtask

   task automatic test_raw();
      @(negedge clk);
      idle();
      issue_valid = 1'b1; issue_rd = 5'd7;
      #1;
      n_checks++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL raw_issue_ready got %b exp %b", issue_ready, 1'b1); end
      @(negedge clk);
      idle();
      rd_addr = {5'd7, 5'd5};
      #1;
      n_checks++; if (rd_busy !== 2'b10) begin n_fail++; $display("FAIL raw_busy got %b exp %b", rd_busy, 2'b10); end
      n_checks++; if (rd_busy_nb !== 2'b10) begin n_fail++; $display("FAIL raw_busy_nb got %b exp %b", rd_busy_nb, 2'b10); end
      @(negedge clk);
      wb_valid = 1'b1; wb_addr = 5'd7; wb_data = 32'h00001234;
      #1;
      n_checks++; if (rd_busy !== 2'b00) begin n_fail++; $display("FAIL raw_wb_busy got %b exp %b", rd_busy, 2'b00); end
      n_checks++; if (rd_data[63:32] !== 32'h00001234) begin n_fail++; $display("FAIL raw_wb_data got %h exp %h", rd_data[63:32], 32'h00001234); end
      n_checks++; if (rd_busy_nb !== 2'b10) begin n_fail++; $display("FAIL raw_wb_busy_nb got %b exp %b", rd_busy_nb, 2'b10); end
      n_checks++; if (rd_data_nb[63:32] !== 32'h0) begin n_fail++; $display("FAIL raw_wb_data_nb got %h exp %h", rd_data_nb[63:32], 32'h0); end
      @(negedge clk);
      idle();
      #1;
      n_checks++; if (rd_busy_nb !== 2'b00) begin n_fail++; $display("FAIL raw_after_busy_nb got %b exp %b", rd_busy_nb, 2'b00); end
      n_checks++; if (rd_data_nb[63:32] !== 32'h00001234) begin n_fail++; $display("FAIL raw_after_data_nb got %h exp %h", rd_data_nb[63:32], 32'h00001234); end
      n_checks++; if (rd_busy !== 2'b00) begin n_fail++; $display("FAIL raw_after_busy got %b exp %b", rd_busy, 2'b00); end
   endtask

   task automatic test_waw();
      @(negedge clk);
      idle();
      issue_valid = 1'b1; issue_rd = 5'd9;
      #1;
      n_checks++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL waw_first_ready got %b exp %b", issue_ready, 1'b1); end
      @(negedge clk);
      rd_addr = {5'd5, 5'd9};
      #1;
      n_checks++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL waw_blocked got %b exp %b", issue_ready, 1'b0); end
      n_checks++; if (rd_busy !== 2'b01) begin n_fail++; $display("FAIL waw_pending got %b exp %b", rd_busy, 2'b01); end
      @(negedge clk);
      wb_valid = 1'b1; wb_addr = 5'd9; wb_data = 32'h000000AA;
      #1;
      n_checks++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL waw_wb_ready got %b exp %b", issue_ready, 1'b1); end
      n_checks++; if (issue_ready_nb !== 1'b1) begin n_fail++; $display("FAIL waw_wb_ready_nb got %b exp %b", issue_ready_nb, 1'b1); end
      @(negedge clk);
      idle();
      #1;
      n_checks++; if (rd_busy !== 2'b01) begin n_fail++; $display("FAIL waw_still_pending got %b exp %b", rd_busy, 2'b01); end
      n_checks++; if (rd_data[31:0] !== 32'h000000AA) begin n_fail++; $display("FAIL waw_data got %h exp %h", rd_data[31:0], 32'h000000AA); end
      wb_valid = 1'b1; wb_addr = 5'd9; wb_data = 32'h000000BB;
      @(negedge clk);
      idle();
      #1;
      n_checks++; if (rd_busy !== 2'b00) begin n_fail++; $display("FAIL waw_cleared got %b exp %b", rd_busy, 2'b00); end
   endtask

   task automatic test_flush_reset();
      for (int pass = 0; pass < 2; pass++) begin
         @(negedge clk);
         idle();
         issue_valid = 1'b1; issue_rd = 5'd3;
         wb_valid = 1'b1; wb_addr = 5'd10; wb_data = 32'h00001010;
         @(negedge clk);
         idle();
         issue_valid = 1'b1; issue_rd = 5'd4;
         @(negedge clk);
         idle();
         rd_addr = {5'd4, 5'd3};
         issue_valid = 1'b1; issue_rd = 5'd6;
         wb_valid = 1'b1; wb_addr = 5'd11; wb_data = 32'h00000077;
         if (pass == 0) flush = 1'b1;
         else rst_n = 1'b0;
         #1;
         if (pass == 0) begin
            n_checks++; if (rd_busy !== 2'b11) begin n_fail++; $display("FAIL flush_pre_busy got %b exp %b", rd_busy, 2'b11); end
         end else begin
            n_checks++; if (rd_busy !== 2'b00) begin n_fail++; $display("FAIL rst_gate_busy got %b exp %b", rd_busy, 2'b00); end
            n_checks++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL rst_gate_ready got %b exp %b", issue_ready, 1'b0); end
         end
         @(negedge clk);
         idle();
         rst_n = 1'b1;
         rd_addr = {5'd4, 5'd3};
         #1;
         n_checks++; if (rd_busy !== 2'b00) begin n_fail++; $display("FAIL flush_busy pass=%0d got %b exp %b", pass, rd_busy, 2'b00); end
         rd_addr = {5'd6, 5'd6};
         issue_rd = 5'd6;
         #1;
         n_checks++; if (rd_busy !== 2'b00) begin n_fail++; $display("FAIL flush_x6_busy pass=%0d got %b exp %b", pass, rd_busy, 2'b00); end
         n_checks++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL flush_x6_ready pass=%0d got %b exp %b", pass, issue_ready, 1'b1); end
         rd_addr = {5'd11, 5'd10};
         #1;
         if (pass == 0) begin
            n_checks++; if (rd_data !== {32'h00000077, 32'h00001010}) begin n_fail++; $display("FAIL flush_wb_kept got %h exp %h", rd_data, {32'h00000077, 32'h00001010}); end
         end else begin
            n_checks++; if (rd_data !== 64'd0) begin n_fail++; $display("FAIL rst_regs_zero got %h exp %h", rd_data, 64'd0); end
            rd_addr = {5'd9, 5'd5};
            #1;
            n_checks++; if (rd_data_nb !== 64'd0) begin n_fail++; $display("FAIL rst_regs_zero_nb got %h exp %h", rd_data_nb, 64'd0); end
         end
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_write_bypass();
      test_x0();
      test_raw();
      test_waw();
      test_flush_reset();
      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
